// File: rtl/vm_pkg.sv
// Shared types, prices, coin set and helpers for the vending controller.
// Pure definitions: no latency, no backpressure.
package vm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DELIVER = 2'd2,
      CHANGE  = 2'd3
   } vm_state_e;

   typedef enum logic [1:0] {
      BEV_NONE  = 2'd0,
      BEV_WATER = 2'd1,
      BEV_SODA  = 2'd2,
      BEV_JUICE = 2'd3
   } vm_bev_e;

   localparam logic [1:0] BTN_WATER  = 2'd0;
   localparam logic [1:0] BTN_SODA   = 2'd1;
   localparam logic [1:0] BTN_JUICE  = 2'd2;
   localparam logic [1:0] BTN_CANCEL = 2'd3;

   localparam logic [7:0] PRICE_WATER = 8'd30;
   localparam logic [7:0] PRICE_SODA  = 8'd50;
   localparam logic [7:0] PRICE_JUICE = 8'd80;
   localparam logic [7:0] MAX_CREDIT  = 8'd250;

   localparam int DELIVER_CYCLES = 4;
   localparam int TIMEOUT_CYCLES = 64;

   localparam logic [7:0] COIN_10  = 8'd10;
   localparam logic [7:0] COIN_20  = 8'd20;
   localparam logic [7:0] COIN_50  = 8'd50;
   localparam logic [7:0] COIN_100 = 8'd100;
   localparam logic [7:0] COIN_200 = 8'd200;

   function automatic logic is_valid_coin(input logic [7:0] coin);
      return (coin == COIN_10) || (coin == COIN_20) || (coin == COIN_50) ||
             (coin == COIN_100) || (coin == COIN_200);
   endfunction

   // Cancel has no price; callers must screen it out before using this.
   function automatic logic [7:0] price_of(input logic [1:0] btn);
      case (btn)
         BTN_WATER: return PRICE_WATER;
         BTN_SODA:  return PRICE_SODA;
         default:   return PRICE_JUICE;
      endcase
   endfunction

endpackage

// File: rtl/vm_cycle_timer.sv
// Loadable down-counter; done is high in the last enabled cycle (count == 1).
// Load wins over counting; no backpressure, the owner decides when to enable.
module vm_cycle_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = en && (cnt == W'(1));

endmodule

// File: rtl/vending_machine_ctrl.sv
// Coin-credit vending FSM: button -> beverage_out in 1 cycle, change_out DELIVER_CYCLES+1 later.
// Inputs are dropped outside IDLE/COLLECT; optional COLLECT timeout refund via VM_TIMEOUT_EN.
module vending_machine_ctrl
   import vm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] coin_in,
   input  logic       button_valid,
   input  logic [1:0] button_in,
   output logic [7:0] change_out,
   output logic [1:0] beverage_out,
   output logic [7:0] credit,
   output logic [1:0] state
);

   localparam int DLV_W = $clog2(DELIVER_CYCLES + 1);

   vm_state_e  state_q, state_d;
   vm_bev_e    bev_q, bev_d;
   logic [7:0] credit_q, credit_d;
   logic [7:0] change_q, change_d;
   logic [8:0] sum9;
   logic       coin_ok;
   logic       dlv_load, dlv_done;
   logic       tmo_done;

   assign sum9    = {1'b0, credit_q} + {1'b0, coin_in};
   assign coin_ok = is_valid_coin(coin_in) && (sum9 <= {1'b0, MAX_CREDIT});

   assign dlv_load = (state_q == COLLECT) && (state_d == DELIVER);

   vm_cycle_timer #(.W(DLV_W)) u_dlv_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (dlv_load),
      .load_val (DLV_W'(DELIVER_CYCLES)),
      .en       (state_q == DELIVER),
      .done     (dlv_done)
   );

`ifdef VM_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic tmo_load, tmo_en;

   // Any strobe or accepted coin restarts the idle window.
   assign tmo_load = ((state_q == IDLE) && coin_ok) ||
                     ((state_q == COLLECT) && (button_valid || coin_ok));
   assign tmo_en   = (state_q == COLLECT) && !button_valid && !coin_ok;

   vm_cycle_timer #(.W(TMO_W)) u_tmo_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmo_load),
      .load_val (TMO_W'(TIMEOUT_CYCLES)),
      .en       (tmo_en),
      .done     (tmo_done)
   );
`else
   assign tmo_done = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         credit_q <= '0;
         change_q <= '0;
         bev_q    <= BEV_NONE;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         change_q <= change_d;
         bev_q    <= bev_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      change_d = '0;
      bev_d    = BEV_NONE;
      case (state_q)
         IDLE: begin
            if (coin_ok) begin
               state_d  = COLLECT;
               credit_d = sum9[7:0];
            end
         end
         COLLECT: begin
            // Buttons see pre-coin credit; a coin only lands if we stay here.
            if (button_valid && (button_in == BTN_CANCEL)) begin
               state_d  = CHANGE;
               change_d = credit_q;
               credit_d = '0;
            end else if (button_valid && (credit_q >= price_of(button_in))) begin
               state_d  = DELIVER;
               credit_d = credit_q - price_of(button_in);
               bev_d    = vm_bev_e'(button_in + 2'd1);
            end else if (coin_ok) begin
               credit_d = sum9[7:0];
            end else if (tmo_done) begin
               state_d  = CHANGE;
               change_d = credit_q;
               credit_d = '0;
            end
         end
         DELIVER: begin
            if (dlv_done) begin
               state_d  = CHANGE;
               change_d = credit_q;
               credit_d = '0;
            end else begin
               bev_d = bev_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign change_out   = change_q;
   assign beverage_out = bev_q;
   assign credit       = credit_q;
   assign state        = state_q;

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Bench for vending_machine_ctrl: directed vector table, reset/timeout sequences,
// then random traffic against a schedule-based reference model.
module tb_vending_machine_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] coin_in;
   logic       button_valid;
   logic [1:0] button_in;
   logic [7:0] change_out;
   logic [1:0] beverage_out;
   logic [7:0] credit;
   logic [1:0] state;

   always #5 clk = ~clk;

   vending_machine_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .coin_in      (coin_in),
      .button_valid (button_valid),
      .button_in    (button_in),
      .change_out   (change_out),
      .beverage_out (beverage_out),
      .credit       (credit),
      .state        (state)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input int st, input int cr,
                            input int bev, input int chg);
      chk({tag, ".state"},    int'(state),        st);
      chk({tag, ".credit"},   int'(credit),       cr);
      chk({tag, ".beverage"}, int'(beverage_out), bev);
      chk({tag, ".change"},   int'(change_out),   chg);
   endtask

   task automatic drive_step(input int coin, input bit bv, input int bin);
      coin_in      = 8'(coin);
      button_valid = bv;
      button_in    = 2'(bin);
      @(posedge clk);
      #1;
   endtask

   // Directed vectors: inputs for one cycle and the outputs expected after that edge.
   typedef struct {
      int coin; bit bv; int bin;
      int st; int cr; int bev; int chg;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input int coin, input bit bv, input int bin,
                      input int st, input int cr, input int bev, input int chg);
      vec_t v;
      v.coin = coin; v.bv = bv; v.bin = bin;
      v.st = st; v.cr = cr; v.bev = bev; v.chg = chg;
      vecs.push_back(v);
   endtask

   // Reference model: while a vend/refund is in flight the next outputs are a
   // precomputed schedule; otherwise the pricing rules are applied directly.
   typedef struct { int st; int cr; int bev; int chg; } obs_t;
   obs_t cur;
   obs_t sched[$];
   int   quiet;

   function automatic obs_t mk(input int st, input int cr, input int bev, input int chg);
      obs_t o;
      o.st = st; o.cr = cr; o.bev = bev; o.chg = chg;
      return o;
   endfunction

   task automatic model_reset();
      sched.delete();
      cur   = mk(0, 0, 0, 0);
      quiet = 0;
   endtask

   task automatic model_step(input int coin, input bit bv, input int bin);
      bit ok;
      int price;
      int left;
      ok = ((coin == 10) || (coin == 20) || (coin == 50) || (coin == 100) || (coin == 200))
           && (cur.cr + coin <= 250);
      price = (bin == 0) ? 30 : (bin == 1) ? 50 : 80;
      if (sched.size() > 0) begin
         cur = sched.pop_front();
      end else if (cur.st == 0) begin
         if (ok) begin
            cur   = mk(1, coin, 0, 0);
            quiet = 0;
         end
      end else if (bv && bin == 3) begin
         cur = mk(3, 0, 0, cur.cr);
         sched.push_back(mk(0, 0, 0, 0));
      end else if (bv && cur.cr >= price) begin
         left = cur.cr - price;
         cur  = mk(2, left, bin + 1, 0);
         repeat (3) sched.push_back(cur);
         sched.push_back(mk(3, 0, 0, left));
         sched.push_back(mk(0, 0, 0, 0));
      end else begin
         if (ok) cur.cr = cur.cr + coin;
         if (bv || ok) quiet = 0;
         else          quiet++;
`ifdef VM_TIMEOUT_EN
         if (quiet == 64) begin
            cur = mk(3, 0, 0, cur.cr);
            sched.push_back(mk(0, 0, 0, 0));
         end
`endif
      end
   endtask

   task automatic do_reset();
      coin_in      = '0;
      button_valid = 1'b0;
      button_in    = '0;
      rst          = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   int coin_pool [11];

   initial begin
      rst          = 1'b1;
      coin_in      = '0;
      button_valid = 1'b0;
      button_in    = '0;
      #1 rst = 1'b0;
      #1 check_all("reset", 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Two small coins, water, hold for four cycles, zero change.
      add(10, 0, 0, 1, 10, 0, 0);
      add(20, 0, 0, 1, 30, 0, 0);
      add(0,  1, 0, 2, 0,  1, 0);
      repeat (3) add(0, 0, 0, 2, 0, 1, 0);
      add(0,  0, 0, 3, 0,  0, 0);
      add(0,  0, 0, 0, 0,  0, 0);
      // Soda from 100; coin and cancel during delivery are ignored.
      add(100, 0, 0, 1, 100, 0, 0);
      add(0,   1, 1, 2, 50,  2, 0);
      add(50,  0, 0, 2, 50,  2, 0);
      add(0,   1, 3, 2, 50,  2, 0);
      add(0,   0, 0, 2, 50,  2, 0);
      add(0,   0, 0, 3, 0,   0, 50);
      add(0,   0, 0, 0, 0,   0, 0);
      // Invalid coin, button in IDLE, unaffordable water, cancel.
      add(25, 0, 0, 0, 0,  0, 0);
      add(0,  1, 3, 0, 0,  0, 0);
      add(20, 0, 0, 1, 20, 0, 0);
      add(0,  1, 0, 1, 20, 0, 0);
      add(0,  1, 3, 3, 0,  0, 20);
      add(0,  0, 0, 0, 0,  0, 0);
      // Credit ceiling.
      add(200, 0, 0, 1, 200, 0, 0);
      add(50,  0, 0, 1, 250, 0, 0);
      add(10,  0, 0, 1, 250, 0, 0);
      add(0,   1, 3, 3, 0,   0, 250);
      add(0,   0, 0, 0, 0,   0, 0);
      // Coin with button: accepted when button is ignored, dropped when it vends.
      add(20, 0, 0, 1, 20, 0, 0);
      add(10, 1, 0, 1, 30, 0, 0);
      add(50, 1, 0, 2, 0,  1, 0);
      repeat (3) add(0, 0, 0, 2, 0, 1, 0);
      add(0,  0, 0, 3, 0,  0, 0);
      add(0,  0, 0, 0, 0,  0, 0);
      // Cancel with coin, then coin during CHANGE.
      add(100, 0, 0, 1, 100, 0, 0);
      add(200, 1, 3, 3, 0,   0, 100);
      add(50,  0, 0, 0, 0,   0, 0);
      // Juice with change.
      add(50, 0, 0, 1, 50,  0, 0);
      add(50, 0, 0, 1, 100, 0, 0);
      add(0,  1, 2, 2, 20,  3, 0);
      repeat (3) add(0, 0, 0, 2, 20, 3, 0);
      add(0,  0, 0, 3, 0,   0, 20);
      add(0,  0, 0, 0, 0,   0, 0);
      // Credit exactly equal to price.
      add(50, 0, 0, 1, 50, 0, 0);
      add(0,  1, 1, 2, 0,  2, 0);
      repeat (3) add(0, 0, 0, 2, 0, 2, 0);
      add(0,  0, 0, 3, 0,  0, 0);
      add(0,  0, 0, 0, 0,  0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive_step(vecs[i].coin, vecs[i].bv, vecs[i].bin);
         check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].cr, vecs[i].bev, vecs[i].chg);
      end

      // Asynchronous reset in the middle of a vend.
      drive_step(100, 0, 0);
      check_all("rstdlv.coin", 1, 100, 0, 0);
      drive_step(0, 1, 1);
      check_all("rstdlv.vend", 2, 50, 2, 0);
      drive_step(50, 0, 0);
      check_all("rstdlv.hold", 2, 50, 2, 0);
      #2 rst = 1'b0;
      #1 check_all("rstdlv.async", 0, 0, 0, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      drive_step(0, 0, 0);
      check_all("rstdlv.after", 0, 0, 0, 0);

      // Inactivity in COLLECT.
      drive_step(20, 0, 0);
      check_all("tmo.coin", 1, 20, 0, 0);
      repeat (63) drive_step(0, 0, 0);
      check_all("tmo.q63", 1, 20, 0, 0);
      drive_step(0, 0, 0);
`ifdef VM_TIMEOUT_EN
      check_all("tmo.q64", 3, 0, 0, 20);
      drive_step(0, 0, 0);
      check_all("tmo.q65", 0, 0, 0, 0);
`else
      check_all("tmo.q64", 1, 20, 0, 0);
      drive_step(0, 0, 0);
      check_all("tmo.q65", 1, 20, 0, 0);
`endif

      // Random traffic against the model.
      coin_pool = '{0, 0, 0, 0, 10, 20, 50, 100, 200, 30, 255};
      do_reset();
      check_all("rnd.reset", cur.st, cur.cr, cur.bev, cur.chg);
      for (int n = 0; n < 3000; n++) begin
         int c, b;
         bit v;
         if (n % 700 == 699) begin
            do_reset();
            check_all($sformatf("rnd%0d.reset", n), cur.st, cur.cr, cur.bev, cur.chg);
         end
         c = coin_pool[$urandom_range(0, 10)];
         v = ($urandom_range(0, 3) == 0);
         b = $urandom_range(0, 3);
         drive_step(c, v, b);
         model_step(c, v, b);
         check_all($sformatf("rnd%0d", n), cur.st, cur.cr, cur.bev, cur.chg);
         chk($sformatf("rnd%0d.exclusive", n),
             int'((change_out != 8'd0) && (beverage_out != 2'd0)), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
